ctx_save_seq: RTL and testbench
===============================

// Module: ctx_save_seq
// PURPOSE
//  Multi-cycle sequencer for the PUSH/POP instructions: saves or restores N_SAVE register-file words to/from an internal frame stack.
//  Sits beside the decoder and pc. Owns the register-file port while active and stalls the pc until the transfer completes.
// PARAMETERS
//  VALUE_WIDTH     8  width of one register-file word
//  RF_ADDR_WIDTH   4  register-file address width
//  N_SAVE          4  registers per frame, addresses 0..N_SAVE-1 (2..2**RF_ADDR_WIDTH)
//  DEPTH           4  frames held in the stack (>=1)
// PORTS
//  clk        in   1              system clock, rising edge
//  rst        in   1              asynchronous, active-low reset
//  push       in   1              decoder: current instruction is PUSH (level, held while pc stalled)
//  pop        in   1              decoder: current instruction is POP (level)
//  stall      out  1              hold pc instr_addr this cycle
//  busy       out  1              state != IDLE
//  rf_addr    out  RF_ADDR_WIDTH  register-file address while busy, else 0
//  rf_rdata   in   VALUE_WIDTH    register-file read data for rf_addr (combinational read)
//  rf_wdata   out  VALUE_WIDTH    restore data
//  rf_we      out  1              register-file write strobe
//  frames     out  $clog2(DEPTH+1) frames currently stored
//  ovf        out  1              push attempted with frames==DEPTH
//  unf        out  1              pop attempted with frames==0
// BEHAVIOUR
//  - Reset: state IDLE, cnt=0, frames=0, stall=busy=rf_we=ovf=unf=0, rf_addr=rf_wdata=0. Frame RAM contents not cleared.
//  - States: IDLE, SAVE, RESTORE, ERROR (ERROR only with trap feature).
//  - IDLE + push + frames<DEPTH: stall=1 (combinational), next SAVE, cnt<=0. Push beats pop if both are high.
//  - IDLE + pop (no push) + frames>0: stall=1, next RESTORE, cnt<=0.
//  - SAVE: rf_addr=cnt. RAM[frames*N_SAVE+cnt]<=rf_rdata at the edge. cnt++.
//    On cnt==N_SAVE-1: frames++, next IDLE, stall=0 this cycle so the pc advances.
//  - RESTORE: rf_addr=cnt, rf_wdata=RAM[(frames-1)*N_SAVE+cnt], rf_we=1. cnt++.
//    On cnt==N_SAVE-1: frames--, next IDLE, stall=0 this cycle.
//  - Latency: PUSH/POP occupy N_SAVE+1 cycles (1 accept + N_SAVE transfer).
//    stall is high for exactly N_SAVE cycles; the last transfer cycle has stall=0.
//  - push/pop are ignored while busy (the level is still held by the stalled pc). No re-trigger, because the pc advances on the final cycle.
//  - frames never exceeds DEPTH or wraps below 0. Index arithmetic is unsigned at $clog2(DEPTH*N_SAVE) bits.
//  - Reset mid-transfer: immediate return to IDLE. A partially written frame is discarded (frames unchanged). A partial restore leaves the registers already written.
// CONFIGURATION
//  CTX_SAVE_ERR_TRAP_EN defined:
//   - Overflow or underflow enters ERROR. ovf/unf is sticky high, stall=1 permanently, busy=1, rf_we=0.
//   - Only reset exits ERROR.
//  CTX_SAVE_ERR_TRAP_EN undefined:
//   - The offending instruction is a no-op: stall=0, frames unchanged.
//   - ovf/unf is high for that single cycle only (combinational).
//   - No ERROR state is generated.
// STRUCTURE
//  - Shared package: state typedef ctx_state_t {IDLE,SAVE,RESTORE,ERROR}, default widths (VALUE_WIDTH, RF_ADDR_WIDTH), macro name constant. Lives with instructions.sv constants.
//  - Sub-module ctx_frame_ram: DEPTH*N_SAVE x VALUE_WIDTH, sync write, async read, no reset.
//  - Top: FSM, cnt, frames, stall/ovf/unf logic.
// TESTING  (N_SAVE=4, DEPTH=2, VALUE_WIDTH=8)
//  1. rf holds 0x11,0x22,0x33,0x44; push level for 5 cycles.
//     -> stall high cycles 1-4, low cycle 5; rf_addr 0..3 in SAVE; frames=1.
//  2. After 1, overwrite rf with 0; pop.
//     -> rf_we 4 cycles, rf_wdata 0x11,0x22,0x33,0x44 to addr 0..3; frames=0; stall pattern as in 1.
//  3. Two pushes of different data, then two pops.
//     -> LIFO order: second frame restored first. frames 2->1->0.
//  4. Third push with frames=2.
//     -> trap off: ovf 1-cycle pulse, stall=0, frames=2.
//     -> trap on: ovf and stall stay high until rst.
//  5. pop with frames=0 -> unf, same split as 4. Also push&pop together in IDLE -> SAVE taken.
//  6. rst low during SAVE cnt=2 -> all outputs 0 asynchronously, frames stays 0. A following push/pop pair restores fresh data.

Source files
------------

// File: rtl/ctx_save_seq_pkg.sv
// Shared types and default widths for the PUSH/POP context-save sequencer.
// The optional error trap is selected with the CTX_SAVE_ERR_TRAP_EN macro.
package ctx_save_seq_pkg;

    localparam int VALUE_WIDTH_DEF   = 8;
    localparam int RF_ADDR_WIDTH_DEF = 4;

    localparam string CTX_TRAP_MACRO_NAME = "CTX_SAVE_ERR_TRAP_EN";

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SAVE    = 2'b01,
        RESTORE = 2'b10,
        ERROR   = 2'b11
    } ctx_state_t;

    // Index width that never collapses to zero bits for tiny configurations.
    function automatic int ctx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ctx_frame_ram.sv
// Frame storage for the context-save sequencer: synchronous write,
// asynchronous read, contents deliberately not reset.
module ctx_frame_ram
    import ctx_save_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ENTRIES    = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [ENTRIES];

    // Write port: one word per SAVE cycle.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ctx_save_seq.sv
// PUSH/POP sequencer: copies N_SAVE register-file words into or out of a
// LIFO frame stack while stalling the pc. Trap mode: CTX_SAVE_ERR_TRAP_EN.
module ctx_save_seq
    import ctx_save_seq_pkg::*;
#(
    parameter int VALUE_WIDTH   = VALUE_WIDTH_DEF,
    parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
    parameter int N_SAVE        = 4,
    parameter int DEPTH         = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    output logic                         stall_o,
    output logic                         busy_o,
    output logic [RF_ADDR_WIDTH-1:0]     rf_addr_o,
    input  logic [VALUE_WIDTH-1:0]       rf_rdata_i,
    output logic [VALUE_WIDTH-1:0]       rf_wdata_o,
    output logic                         rf_we_o,
    output logic [$clog2(DEPTH+1)-1:0]   frames_o,
    output logic                         ovf_o,
    output logic                         unf_o
);

    localparam int FW      = $clog2(DEPTH + 1);
    localparam int CW      = ctx_width(N_SAVE);
    localparam int ENTRIES = DEPTH * N_SAVE;
    localparam int IDXW    = ctx_width(ENTRIES);

    localparam logic [CW-1:0] CNT_LAST    = CW'(N_SAVE - 1);
    localparam logic [FW-1:0] FRAMES_FULL = FW'(DEPTH);
    localparam logic [FW-1:0] FRAMES_NONE = {FW{1'b0}};

    ctx_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [FW-1:0]    frames_q, frames_d;

    logic             stall_s;
    logic             ram_we_s;
    logic             rf_we_s;
    logic             ovf_det_s;
    logic             unf_det_s;
    logic [FW-1:0]    frame_sel_s;
    logic [IDXW-1:0]  ram_idx_s;
    logic [VALUE_WIDTH-1:0] ram_rdata_s;

    // Frame slot being transferred: next free frame on SAVE, top frame on RESTORE.
    always_comb begin
        frame_sel_s = frames_q;
        if (state_q == RESTORE) begin
            frame_sel_s = frames_q - FW'(1);
        end else begin
            frame_sel_s = frames_q;
        end
        ram_idx_s = IDXW'(IDXW'(frame_sel_s) * IDXW'(N_SAVE)) + IDXW'(cnt_q);
    end

    // Next-state, counter, frame count and strobe decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frames_d  = frames_q;
        stall_s   = 1'b0;
        ram_we_s  = 1'b0;
        rf_we_s   = 1'b0;
        ovf_det_s = 1'b0;
        unf_det_s = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = {CW{1'b0}};
                if (push_i) begin
                    if (frames_q != FRAMES_FULL) begin
                        stall_s = 1'b1;
                        state_d = SAVE;
                    end else begin
                        ovf_det_s = 1'b1;
`ifdef CTX_SAVE_ERR_TRAP_EN
                        stall_s = 1'b1;
                        state_d = ERROR;
`else
                        state_d = IDLE;
`endif
                    end
                end else if (pop_i) begin
                    if (frames_q != FRAMES_NONE) begin
                        stall_s = 1'b1;
                        state_d = RESTORE;
                    end else begin
                        unf_det_s = 1'b1;
`ifdef CTX_SAVE_ERR_TRAP_EN
                        stall_s = 1'b1;
                        state_d = ERROR;
`else
                        state_d = IDLE;
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SAVE: begin
                ram_we_s = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Final beat: release the pc now so the level does not re-trigger.
                    stall_s  = 1'b0;
                    cnt_d    = {CW{1'b0}};
                    frames_d = frames_q + FW'(1);
                    state_d  = IDLE;
                end else begin
                    stall_s = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            RESTORE: begin
                rf_we_s = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    stall_s  = 1'b0;
                    cnt_d    = {CW{1'b0}};
                    frames_d = frames_q - FW'(1);
                    state_d  = IDLE;
                end else begin
                    stall_s = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
`ifdef CTX_SAVE_ERR_TRAP_EN
            ERROR: begin
                stall_s = 1'b1;
                state_d = ERROR;
            end
`endif
            default: begin
                cnt_d   = {CW{1'b0}};
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, beat counter and stack depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            frames_q <= {FW{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frames_q <= frames_d;
        end
    end

`ifdef CTX_SAVE_ERR_TRAP_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    assign ovf_d = ovf_q | ovf_det_s;
    assign unf_d = unf_q | unf_det_s;

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf_o = ovf_q | ovf_det_s;
    assign unf_o = unf_q | unf_det_s;
`else
    assign ovf_o = ovf_det_s;
    assign unf_o = unf_det_s;
`endif

    ctx_frame_ram #(
        .WIDTH      (VALUE_WIDTH),
        .ENTRIES    (ENTRIES),
        .ADDR_WIDTH (IDXW)
    ) u_frame_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we_s),
        .addr_i  (ram_idx_s),
        .wdata_i (rf_rdata_i),
        .rdata_o (ram_rdata_s)
    );

    assign stall_o    = stall_s;
    assign busy_o     = (state_q != IDLE);
    assign rf_addr_o  = (state_q != IDLE) ? RF_ADDR_WIDTH'(cnt_q) : {RF_ADDR_WIDTH{1'b0}};
    assign rf_wdata_o = (state_q == RESTORE) ? ram_rdata_s : {VALUE_WIDTH{1'b0}};
    assign rf_we_o    = rf_we_s;
    assign frames_o   = frames_q;

endmodule

// File: tb/tb_ctx_save_seq.sv
// Cycle-table bench for ctx_save_seq (N_SAVE=4, DEPTH=2) with a restore-data
// scoreboard; follows CTX_SAVE_ERR_TRAP_EN for the overflow/underflow split.
module tb_ctx_save_seq;

    typedef struct packed {
        logic       stall;
        logic       busy;
        logic [3:0] addr;
        logic       we;
        logic [1:0] frames;
        logic       ovf;
        logic       unf;
    } out_t;

    typedef struct {
        logic        load;
        logic [31:0] rfw;
        logic        push;
        logic        pop;
        out_t        exp;
    } vec_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       stall, busy, rf_we, ovf, unf;
    logic [3:0] rf_addr;
    logic [7:0] rf_rdata, rf_wdata;
    logic [1:0] frames;

    logic [7:0]  rf_mem [16];
    vec_t        tbl [$];
    logic [31:0] stk [$];
    wr_t         sb_q [$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          step_no = 0;

    always #5 clk = ~clk;

    assign rf_rdata = rf_mem[rf_addr];

    ctx_save_seq #(
        .VALUE_WIDTH   (8),
        .RF_ADDR_WIDTH (4),
        .N_SAVE        (4),
        .DEPTH         (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .push_i     (push),
        .pop_i      (pop),
        .stall_o    (stall),
        .busy_o     (busy),
        .rf_addr_o  (rf_addr),
        .rf_rdata_i (rf_rdata),
        .rf_wdata_o (rf_wdata),
        .rf_we_o    (rf_we),
        .frames_o   (frames),
        .ovf_o      (ovf),
        .unf_o      (unf)
    );

    function automatic void add(input logic ld, input logic [31:0] w, input logic p, input logic q,
                                input logic st, input logic bz, input logic [3:0] a, input logic we,
                                input logic [1:0] fr, input logic ov, input logic un);
        vec_t v;
        v.load = ld;  v.rfw = w;  v.push = p;  v.pop = q;
        v.exp.stall = st;  v.exp.busy = bz;  v.exp.addr = a;  v.exp.we = we;
        v.exp.frames = fr; v.exp.ovf = ov;   v.exp.unf = un;
        tbl.push_back(v);
    endfunction

    // Full PUSH: accept cycle, four SAVE beats (last one releases stall), one idle cycle.
    function automatic void add_push(input logic [31:0] w, input logic [1:0] fr, input logic with_pop);
        add(1'b1, w, 1'b1, with_pop, 1'b1, 1'b0, 4'd0, 1'b0, fr, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++)
            add(1'b0, 32'd0, 1'b1, with_pop, (c != 3), 1'b1, 4'(c), 1'b0, fr, 1'b0, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, fr + 2'd1, 1'b0, 1'b0);
    endfunction

    // Full POP with the register file cleared first so every restored word is visible.
    function automatic void add_pop(input logic [1:0] fr);
        add(1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, fr, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++)
            add(1'b0, 32'd0, 1'b0, 1'b1, (c != 3), 1'b1, 4'(c), 1'b1, fr, 1'b0, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, fr - 2'd1, 1'b0, 1'b0);
    endfunction

    task automatic step(input vec_t v);
        out_t        act;
        logic [31:0] w;
        wr_t         e;
        @(negedge clk);
        if (v.load)
            for (int i = 0; i < 4; i++) rf_mem[i] = v.rfw[8*i +: 8];
        push = v.push;
        pop  = v.pop;
        #1;
        act = '{stall: stall, busy: busy, addr: rf_addr, we: rf_we, frames: frames, ovf: ovf, unf: unf};
        n_chk++;
        if (act !== v.exp) begin
            n_fail++;
            $display("FAIL step%0d {stall,busy,addr,we,frames,ovf,unf}: got %b expected %b",
                     step_no, act, v.exp);
        end
        if (v.exp.stall && !v.exp.busy && !v.exp.ovf && !v.exp.unf) begin
            if (v.push) begin
                stk.push_back({rf_mem[3], rf_mem[2], rf_mem[1], rf_mem[0]});
            end else if (v.pop && stk.size() > 0) begin
                w = stk.pop_back();
                for (int i = 0; i < 4; i++) begin
                    e.addr = 4'(i);
                    e.data = w[8*i +: 8];
                    sb_q.push_back(e);
                end
            end
        end
        if (rf_we === 1'b1) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL step%0d rf_write: got addr %h data %h, expected no write",
                         step_no, rf_addr, rf_wdata);
            end else begin
                e = sb_q.pop_front();
                if (rf_addr !== e.addr || rf_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL step%0d rf_write: got addr %h data %h, expected addr %h data %h",
                             step_no, rf_addr, rf_wdata, e.addr, e.data);
                end
            end
            rf_mem[rf_addr] = rf_wdata;
        end
        step_no++;
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) step(tbl[i]);
        tbl.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        logic [18:0] act;
        act = {stall, busy, rf_addr, rf_we, rf_wdata, frames, ovf, unf};
        n_chk++;
        if (act !== 19'd0) begin
            n_fail++;
            $display("FAIL %s: outputs {stall,busy,addr,we,wdata,frames,ovf,unf} got %b expected all zero",
                     name, act);
        end
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        #1;
        check_reset_outputs(name);
        stk.delete();
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Single push/pop round trip, then two stacked frames restored in LIFO order.
        add_push(32'h44332211, 2'd0, 1'b0);
        add_pop(2'd1);
        add_push(32'hA4A3A2A1, 2'd0, 1'b0);
        add_push(32'hB4B3B2B1, 2'd1, 1'b0);
`ifndef CTX_SAVE_ERR_TRAP_EN
        add(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd2, 1'b1, 1'b0);
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd2, 1'b0, 1'b0);
`endif
        add_pop(2'd2);
        add_pop(2'd1);
`ifndef CTX_SAVE_ERR_TRAP_EN
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
`endif
        add_push(32'hC4C3C2C1, 2'd0, 1'b1);
        add_pop(2'd1);
        run_tbl();

        // Reset while the SAVE counter sits at 2: nothing of that frame survives.
        add(1'b1, 32'hD4D3D2D1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        add(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        add(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        add(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        run_tbl();
        #2 rst_n = 1'b0;
        push = 1'b0;
        #1 check_reset_outputs("reset_mid_save");
        stk.delete();
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        add_push(32'hE4E3E2E1, 2'd0, 1'b0);
        add_pop(2'd1);
        run_tbl();

`ifdef CTX_SAVE_ERR_TRAP_EN
        // Overflow and underflow lock the sequencer until reset.
        add_push(32'h0F0E0D0C, 2'd0, 1'b0);
        add_push(32'h1F1E1D1C, 2'd1, 1'b0);
        add(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            add(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 2'd2, 1'b1, 1'b0);
        run_tbl();
        pulse_reset("reset_after_ovf");
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        run_tbl();
        pulse_reset("reset_after_unf");
`endif

        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL restore_drain: got %0d pending restore words, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
